// File: rtl/fft_input_buffer.sv
// Ping-pong capture buffer between the 64-point input counter and the FFT core.
// Samples are stored at the bit-reversed index, so the core reads in butterfly order.
// frame_ready and frame_done pass whole banks between the capture side and the core.
module fft_input_buffer #(
    parameter int DW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_en,
    input  logic [5:0]    wr_idx,
    input  logic [DW-1:0] wr_re,
    input  logic [DW-1:0] wr_im,
    input  logic          rd_en,
    input  logic [5:0]    rd_addr,
    output logic [DW-1:0] rd_re,
    output logic [DW-1:0] rd_im,
    output logic          rd_valid,
    output logic          frame_ready,
    input  logic          frame_done,
    output logic          overflow,
    input  logic          clr_ovf
);

    localparam int unsigned DEPTH = 64;

    logic [2*DW-1:0] mem [2][DEPTH];
    logic [1:0]      full;
    logic            wbank;
    logic            rbank;

    logic            accept;
    logic            drop;
    logic            complete;
    logic            rel;
    logic            rd_hit;
    logic [5:0]      wr_addr;

    assign frame_ready = full[rbank];

    // Decode this cycle's write, release and read events; bit-reverse the write index.
    // drop uses the pre-release full flag, so a bank released this cycle accepts from the next.
    always_comb begin
        wr_addr = '0;
        for (int unsigned i = 0; i < 6; i++) begin
            wr_addr[i] = wr_idx[5-i];
        end
        accept   = wr_en & ~full[wbank];
        drop     = wr_en &  full[wbank];
        complete = accept & (wr_idx == 6'd63);
        rel      = frame_done & full[rbank];
        rd_hit   = rd_en & full[rbank];
    end

    // Sample storage: no reset, only accepted writes touch it.
    always_ff @(posedge clk) begin
        if (accept) begin
            mem[wbank][wr_addr] <= {wr_re, wr_im};
        end
    end

    // Bank ownership: completion fills the write bank, release empties the read bank.
    // Both cannot target the same bank in one cycle (one needs it empty, the other full).
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            full  <= '0;
            wbank <= 1'b0;
            rbank <= 1'b0;
        end else begin
            if (complete) begin
                full[wbank] <= 1'b1;
                wbank       <= ~wbank;
            end
            if (rel) begin
                full[rbank] <= 1'b0;
                rbank       <= ~rbank;
            end
        end
    end

    // Registered read port; data holds when no read is granted.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_re    <= '0;
            rd_im    <= '0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= rd_hit;
            if (rd_hit) begin
                {rd_re, rd_im} <= mem[rbank][rd_addr];
            end
        end
    end

    // Sticky overflow flag; a new drop takes priority over the clear.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            overflow <= 1'b0;
        end else if (drop) begin
            overflow <= 1'b1;
        end else if (clr_ovf) begin
            overflow <= 1'b0;
        end
    end

endmodule

// File: tb/tb_fft_input_buffer.sv
// Self-checking bench for fft_input_buffer: directed scenarios plus randomized traffic,
// compared against a frame-queue reference model.
module tb_fft_input_buffer;

    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          wr_en;
    logic [5:0]    wr_idx;
    logic [DW-1:0] wr_re;
    logic [DW-1:0] wr_im;
    logic          rd_en;
    logic [5:0]    rd_addr;
    logic [DW-1:0] rd_re;
    logic [DW-1:0] rd_im;
    logic          rd_valid;
    logic          frame_ready;
    logic          frame_done;
    logic          overflow;
    logic          clr_ovf;

    fft_input_buffer #(.DW(DW)) dut (
        .clk         (clk),
        .rst         (rst),
        .wr_en       (wr_en),
        .wr_idx      (wr_idx),
        .wr_re       (wr_re),
        .wr_im       (wr_im),
        .rd_en       (rd_en),
        .rd_addr     (rd_addr),
        .rd_re       (rd_re),
        .rd_im       (rd_im),
        .rd_valid    (rd_valid),
        .frame_ready (frame_ready),
        .frame_done  (frame_done),
        .overflow    (overflow),
        .clr_ovf     (clr_ovf)
    );

    always #5 clk = ~clk;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    // Reference model: completed frames waiting for the core, in arrival order,
    // each indexed by natural sample number with a mask of which samples were written.
    typedef struct packed {
        logic [63:0]         mask;
        logic [63:0][DW-1:0] re;
        logic [63:0][DW-1:0] im;
    } frame_t;

    frame_t        q[$];
    frame_t        cur;
    logic [DW-1:0] exp_re;
    logic [DW-1:0] exp_im;
    logic          exp_valid;
    logic          exp_ovf;
    bit            data_known;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int unsigned bitrev6(input int unsigned k);
        int unsigned r = 0;
        for (int i = 0; i < 6; i++) begin
            r = r * 2 + ((k >> i) & 1);
        end
        return r;
    endfunction

    task automatic model_reset();
        q.delete();
        cur.mask   = '0;
        exp_re     = '0;
        exp_im     = '0;
        exp_valid  = 1'b0;
        exp_ovf    = 1'b0;
        data_known = 1'b1;
    endtask

    task automatic set_in(input bit we, input int idx, input int re, input int im,
                          input bit re_n, input int addr, input bit done, input bit clr);
        wr_en      = we;
        wr_idx     = 6'(idx);
        wr_re      = DW'(re);
        wr_im      = DW'(im);
        rd_en      = re_n;
        rd_addr    = 6'(addr);
        frame_done = done;
        clr_ovf    = clr;
    endtask

    // One clock: advance the model with the inputs held across the edge, then compare.
    task automatic cycle();
        bit          blocked;
        int unsigned s;
        @(posedge clk);
        #1;
        blocked = (q.size() == 2);
        if (rd_en && q.size() > 0) begin
            exp_valid = 1'b1;
            s = bitrev6(int'(rd_addr));
            if (q[0].mask[s]) begin
                exp_re     = q[0].re[s];
                exp_im     = q[0].im[s];
                data_known = 1'b1;
            end else begin
                data_known = 1'b0;
            end
        end else begin
            exp_valid = 1'b0;
        end
        if (frame_done && q.size() > 0) void'(q.pop_front());
        if (wr_en && blocked) begin
            exp_ovf = 1'b1;
        end else begin
            if (clr_ovf) exp_ovf = 1'b0;
            if (wr_en) begin
                cur.mask[wr_idx] = 1'b1;
                cur.re[wr_idx]   = wr_re;
                cur.im[wr_idx]   = wr_im;
                if (wr_idx == 6'd63) begin
                    q.push_back(cur);
                    cur.mask = '0;
                end
            end
        end
        check("frame_ready", 32'(frame_ready), 32'(q.size() > 0));
        check("rd_valid", 32'(rd_valid), 32'(exp_valid));
        check("overflow", 32'(overflow), 32'(exp_ovf));
        if (data_known) begin
            check("rd_re", 32'(rd_re), 32'(exp_re));
            check("rd_im", 32'(rd_im), 32'(exp_im));
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            set_in(0, 0, 0, 0, 0, 0, 0, 0);
            cycle();
        end
    endtask

    task automatic do_reset();
        set_in(0, 0, 0, 0, 0, 0, 0, 0);
        rst = 1'b0;
        #1;
        model_reset();
        check("rst_rd_re", 32'(rd_re), 32'd0);
        check("rst_rd_im", 32'(rd_im), 32'd0);
        check("rst_rd_valid", 32'(rd_valid), 32'd0);
        check("rst_frame_ready", 32'(frame_ready), 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);
        @(negedge clk);
        rst = 1'b1;
    endtask

    // Full frame with re = base + n, im = -(base + n); optional frame_done on the idx-63 write.
    task automatic write_frame(input int base, input bit done_at_last);
        for (int n = 0; n < 64; n++) begin
            set_in(1, n, base + n, -(base + n), 0, 0, done_at_last && n == 63, 0);
            cycle();
        end
    endtask

    task automatic read_one(input int addr, input bit done);
        set_in(0, 0, 0, 0, 1, addr, done, 0);
        cycle();
    endtask

    initial begin
        int unsigned cnt;
        rst = 1'b0;
        set_in(0, 0, 0, 0, 0, 0, 0, 0);
        model_reset();
        #12;
        do_reset();
        idle(2);

        // 1: single frame, bit-reversed read-back
        write_frame(0, 0);
        check("t1_ready", 32'(frame_ready), 32'd1);
        read_one(1, 0);
        check("t1_valid_a1", 32'(rd_valid), 32'd1);
        check("t1_re_a1", 32'(rd_re), 32'd32);
        read_one(6, 0);
        check("t1_re_a6", 32'(rd_re), 32'd24);
        check("t1_im_a6", 32'(rd_im), 32'(16'hffe8));
        read_one(0, 1);
        idle(1);
        check("t1_released", 32'(frame_ready), 32'd0);

        // 2: two frames fill the buffer, third is dropped
        write_frame(0, 0);
        write_frame(100, 0);
        write_frame(300, 0);
        check("t2_ovf", 32'(overflow), 32'd1);
        set_in(0, 0, 0, 0, 0, 0, 1, 0);
        cycle();
        read_one(0, 0);
        check("t2_re_a0", 32'(rd_re), 32'd100);
        read_one(63, 1);
        check("t2_re_a63", 32'(rd_re), 32'd163);
        set_in(0, 0, 0, 0, 0, 0, 0, 1);
        cycle();
        check("t2_ovf_clr", 32'(overflow), 32'd0);

        // 3: release and completion in the same cycle
        write_frame(400, 0);
        write_frame(500, 1);
        check("t3_ready", 32'(frame_ready), 32'd1);
        read_one(2, 0);
        check("t3_re_a2", 32'(rd_re), 32'd516);
        read_one(0, 1);
        idle(1);

        // 4: asynchronous reset mid-frame, then a fresh frame
        for (int n = 0; n <= 30; n++) begin
            set_in(1, n, 700 + n, 0, 0, 0, 0, 0);
            cycle();
        end
        #2;
        do_reset();
        idle(1);
        write_frame(200, 0);
        read_one(0, 0);
        check("t4_re_a0", 32'(rd_re), 32'd200);
        read_one(1, 0);
        check("t4_re_a1", 32'(rd_re), 32'd232);
        read_one(0, 1);
        idle(1);

        // 5: frame_done and rd_en with nothing ready
        set_in(0, 0, 0, 0, 1, 5, 1, 0);
        cycle();
        check("t5_valid", 32'(rd_valid), 32'd0);
        check("t5_ready", 32'(frame_ready), 32'd0);
        check("t5_hold_re", 32'(rd_re), 32'd200);

        // 6: drop and clear in the same cycle, then clear alone
        write_frame(800, 0);
        write_frame(900, 0);
        set_in(1, 0, 1, 1, 0, 0, 0, 1);
        cycle();
        check("t6_set_wins", 32'(overflow), 32'd1);
        set_in(0, 0, 0, 0, 0, 0, 0, 1);
        cycle();
        check("t6_clr", 32'(overflow), 32'd0);
        set_in(0, 0, 0, 0, 0, 0, 1, 0);
        cycle();
        set_in(0, 0, 0, 0, 0, 0, 1, 0);
        cycle();

        // Randomized traffic: counter-ordered writes with gaps, random reads/releases/clears
        cnt = 0;
        for (int c = 0; c < 4000; c++) begin
            bit we;
            we = ($urandom_range(0, 9) < 7);
            set_in(we, int'(cnt), int'($urandom), int'($urandom),
                   $urandom_range(0, 1) == 1, int'($urandom_range(0, 63)),
                   $urandom_range(0, 99) < 3, $urandom_range(0, 99) < 4);
            if (we) cnt = (cnt + 1) % 64;
            cycle();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
